sys_tx_ctrl: RTL and testbench
==============================

# sys_tx_ctrl

UART transmit sequencer for the system controller. Accepts reg-file read results (8 bit) and ALU results (16 bit) from the receive-side controller, buffers one pending request per source and arbitrates between them. It serializes each result into byte frames on the single UART TX parallel interface, using a valid/busy handshake with the UART transmitter. It sits in the reference-clock domain between the receive-side controller and the UART TX synchronizer/FIFO.

## Interface
- DATA_WIDTH, 8, byte width of UART frames and reg-file data
- clk  in  1  system reference clock
- rst  in  1  asynchronous reset, active-low
- reg_send  in  1  one-cycle pulse: reg_data valid, send 1 byte
- reg_data  in  DATA_WIDTH  reg-file read result
- alu_send  in  1  one-cycle pulse: alu_data valid, send 2 bytes
- alu_data  in  2*DATA_WIDTH  ALU result
- tx_busy  in  1  UART transmitter busy (high while a frame is shifting)
- tx_data  out  DATA_WIDTH  byte presented to UART TX, registered
- tx_valid  out  1  one-cycle strobe: tx_data ready for UART TX
- ctrl_busy  out  1  high when FSM not IDLE or any request pending
- ovf  out  1  one-cycle pulse: pending request of same source overwritten

## Operation
- Two request slots (reg, alu), each a holding register plus pending flag. A send pulse loads its data and sets pending on the same edge.
- Send pulse while that slot is already pending: data overwritten, pending stays 1, ovf pulses the following cycle. A send pulse while the slot's request is in service is not an overflow; it is accepted into the freed slot.
- Slot contents are copied into the service register when the FSM leaves IDLE, and pending clears on that edge.
- Arbitration in IDLE: reg has fixed priority over alu when both are pending. Requests never preempt a transfer in progress.
- ALU byte order: alu_data[7:0] first, then alu_data[15:8]. Reg: single byte.
- FSM states:
  - IDLE: any pending -> SEND (byte index 0, byte count 1 or 2).
  - SEND: tx_valid=1 for exactly this cycle, tx_data = current byte -> WAIT_ACK.
  - WAIT_ACK: tx_busy=1 -> WAIT_DONE; otherwise stay.
  - WAIT_DONE: tx_busy=0 -> SEND if bytes remain (index+1), otherwise IDLE.
- tx_data is held stable from SEND through the end of WAIT_DONE. It changes only on entry to SEND.
- Undefined state encoding -> IDLE, outputs at reset values.

## Timing
- Reset (async, rst=0): tx_data=0, tx_valid=0, ctrl_busy=0, ovf=0, both slots empty, FSM IDLE. Reset mid-transfer aborts immediately, and pending requests are discarded.
- Request pulse at edge N sets pending; FSM enters SEND at edge N+1; tx_valid is high in cycle N+1..N+2. Latency is 2 clk from pulse to strobe.
- Simultaneous reg_send and alu_send in IDLE: reg byte sent first, alu bytes follow with no return to arbitration delay beyond one IDLE cycle.
- Inter-byte gap for ALU: the second SEND follows the tx_busy falling edge by one cycle.
- ctrl_busy is combinational from the FSM state and pending flags, and rises in the cycle after the request pulse.
- tx_busy already high in IDLE is ignored until SEND. WAIT_ACK has no timeout; it waits indefinitely.

## Structure
- Shared package sys_ctrl_pkg holds the FSM state encodings (IDLE, SEND, WAIT_ACK, WAIT_DONE) and the byte-order/byte-count constants. Command opcodes (AA/BB/CC/DD) already live there.
- Natural sub-module: tx_req_slot (parameterized width), a holding register plus pending flag with overflow pulse. It is instantiated twice, at widths DATA_WIDTH and 2*DATA_WIDTH.
- Top level holds the arbiter, FSM, byte index counter and tx_data register.

## Test plan
- reg_send with reg_data=8'h5A, model holds tx_busy high 10 cycles after strobe -> single tx_valid, tx_data=8'h5A 2 cycles after pulse, IDLE after busy falls, ctrl_busy low.
- alu_send with alu_data=16'hBEEF -> two strobes, tx_data=8'hEF then 8'hBE, second strobe one cycle after first busy fall.
- reg_send=8'h11 and alu_send=16'h2233 same cycle -> byte stream 11, 33, 22; no ovf.
- During ALU transfer, reg_send 8'hA1 then reg_send 8'hA2 -> ovf pulses once; after ALU bytes, only A2 is sent.
- rst asserted in WAIT_DONE of the first ALU byte, with a reg request pending -> all outputs 0 immediately; after release, no strobe occurs without a new pulse.
- tx_busy never rises after a strobe -> FSM stays in WAIT_ACK, tx_data held, no further tx_valid.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared system-controller constants and the TX sequencer FSM encoding
package sys_ctrl_pkg;

  localparam int DATA_WIDTH = 8;

  // Command opcodes decoded by the receive-side controller.
  localparam logic [7:0] CMD_REG_WR  = 8'hAA;
  localparam logic [7:0] CMD_REG_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // Frames per result and the order ALU halves go out: low byte first.
  localparam logic [1:0] REG_BYTE_CNT  = 2'd1;
  localparam logic [1:0] ALU_BYTE_CNT  = 2'd2;
  localparam logic       ALU_FIRST_IDX = 1'b0;

  function automatic logic is_last_byte(input logic idx, input logic [1:0] count);
    return ({1'b0, idx} + 2'd1) >= count;
  endfunction

endpackage

// File: rtl/tx_req_slot.sv
// rtl/tx_req_slot.sv - one-deep request holding register with pending flag and overwrite pulse
module tx_req_slot #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_take,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pending,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_data;
  logic             r_pending;
  logic             r_ovf;

  // A load on the same edge as a take refills the freed slot; that is not an overwrite.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data    <= '0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
      end
      r_pending <= i_load | (r_pending & ~i_take);
      r_ovf     <= i_load & r_pending & ~i_take;
    end
  end

  assign o_data    = r_data;
  assign o_pending = r_pending;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/sys_tx_ctrl.sv
// rtl/sys_tx_ctrl.sv - UART TX sequencer: buffers reg/ALU results, arbitrates, serializes bytes
module sys_tx_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = sys_ctrl_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reg_send,
  input  logic [DATA_WIDTH-1:0]   reg_data,
  input  logic                    alu_send,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    ctrl_busy,
  output logic                    ovf
);

  tx_state_e               r_state;
  tx_state_e               w_next_state;
  logic [2*DATA_WIDTH-1:0] r_svc;
  logic [1:0]              r_count;
  logic                    r_idx;
  logic [DATA_WIDTH-1:0]   r_tx_data;

  logic [DATA_WIDTH-1:0]   w_reg_q;
  logic [2*DATA_WIDTH-1:0] w_alu_q;
  logic                    w_reg_pend;
  logic                    w_alu_pend;
  logic                    w_reg_ovf;
  logic                    w_alu_ovf;
  logic                    w_any_pend;
  logic                    w_take_reg;
  logic                    w_take_alu;
  logic                    w_last;
  logic                    w_next_byte;

  tx_req_slot #(.WIDTH(DATA_WIDTH)) u_reg_slot (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (reg_send),
    .i_data    (reg_data),
    .i_take    (w_take_reg),
    .o_data    (w_reg_q),
    .o_pending (w_reg_pend),
    .o_ovf     (w_reg_ovf)
  );

  tx_req_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (alu_send),
    .i_data    (alu_data),
    .i_take    (w_take_alu),
    .o_data    (w_alu_q),
    .o_pending (w_alu_pend),
    .o_ovf     (w_alu_ovf)
  );

  // Fixed priority: reg wins over alu, and only while idle so a transfer is never preempted.
  assign w_any_pend  = w_reg_pend | w_alu_pend;
  assign w_take_reg  = (r_state == ST_IDLE) & w_reg_pend;
  assign w_take_alu  = (r_state == ST_IDLE) & ~w_reg_pend & w_alu_pend;
  assign w_last      = is_last_byte(r_idx, r_count);
  assign w_next_byte = (r_state == ST_WAIT_DONE) & ~tx_busy & ~w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:      w_next_state = w_any_pend ? ST_SEND : ST_IDLE;
      ST_SEND:      w_next_state = ST_WAIT_ACK;
      ST_WAIT_ACK:  w_next_state = tx_busy ? ST_WAIT_DONE : ST_WAIT_ACK;
      ST_WAIT_DONE: begin
        if (tx_busy) begin
          w_next_state = ST_WAIT_DONE;
        end else if (w_last) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    ctrl_busy = w_any_pend;
    case (r_state)
      ST_IDLE: begin
        tx_valid  = 1'b0;
      end
      ST_SEND: begin
        tx_valid  = 1'b1;
        ctrl_busy = 1'b1;
      end
      ST_WAIT_ACK, ST_WAIT_DONE: begin
        ctrl_busy = 1'b1;
      end
      default: begin
        tx_valid  = 1'b0;
        ctrl_busy = 1'b0;
      end
    endcase
  end

  // tx_data only moves on entry to SEND, so it stays put while the UART shifts the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_svc     <= '0;
      r_count   <= '0;
      r_idx     <= 1'b0;
      r_tx_data <= '0;
    end else if (w_take_reg) begin
      r_svc     <= {{DATA_WIDTH{1'b0}}, w_reg_q};
      r_count   <= REG_BYTE_CNT;
      r_idx     <= 1'b0;
      r_tx_data <= w_reg_q;
    end else if (w_take_alu) begin
      r_svc     <= w_alu_q;
      r_count   <= ALU_BYTE_CNT;
      r_idx     <= ALU_FIRST_IDX;
      r_tx_data <= w_alu_q[DATA_WIDTH-1:0];
    end else if (w_next_byte) begin
      r_idx     <= ~r_idx;
      r_tx_data <= r_svc[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  assign tx_data = r_tx_data;
  assign ovf     = w_reg_ovf | w_alu_ovf;

endmodule

// File: tb/tb_sys_tx_ctrl.sv
// tb/tb_sys_tx_ctrl.sv - self-checking bench for sys_tx_ctrl with UART busy model and byte scoreboard
module tb_sys_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_send = 1'b0;
  logic [7:0]  reg_data = '0;
  logic        alu_send = 1'b0;
  logic [15:0] alu_data = '0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ctrl_busy;
  logic        ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          busy_len = 10;
  logic        busy_en = 1'b1;
  int          fall_cyc = 0;
  int          strobe_cnt = 0;
  int          ovf_cnt = 0;
  int          gap [0:31];
  logic [7:0]  prev_tx_data = '0;
  logic [7:0]  sb [$];

  sys_tx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .reg_send  (reg_send),
    .reg_data  (reg_data),
    .alu_send  (alu_send),
    .alu_data  (alu_data),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .ctrl_busy (ctrl_busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: goes busy after a strobe and stays busy busy_len cycles.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else if (tx_valid && busy_en) begin
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) fall_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (ovf) ovf_cnt = ovf_cnt + 1;
    if (rst && !tx_valid) chk("tx_data_hold", tx_data, prev_tx_data);
    if (tx_valid) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) chk("tx_byte", tx_data, sb.pop_front());
      if (strobe_cnt < 32) gap[strobe_cnt] = cyc - fall_cyc;
      strobe_cnt = strobe_cnt + 1;
    end
    prev_tx_data = tx_data;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int target, input string tag);
    int n = 0;
    while (strobe_cnt < target && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, strobe_cnt >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (ctrl_busy !== 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, ctrl_busy, 0);
  endtask

  initial begin
    int ovf_base;

    // Reset state
    tick(2);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ctrl_busy", ctrl_busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    tick(3);

    // Single reg byte, 2-cycle latency
    reg_send = 1'b1; reg_data = 8'h5A; sb.push_back(8'h5A);
    tick(1);
    reg_send = 1'b0;
    chk("t1_busy_after_pulse", ctrl_busy, 1);
    chk("t1_no_strobe_yet", tx_valid, 0);
    tick(1);
    chk("t1_strobe", tx_valid, 1);
    chk("t1_data", tx_data, 8'h5A);
    wait_idle("t1_idle");
    chk("t1_strobe_cnt", strobe_cnt, 1);
    chk("t1_data_held", tx_data, 8'h5A);
    tick(2);

    // ALU word, low byte first, second strobe one cycle after busy falls
    alu_send = 1'b1; alu_data = 16'hBEEF; sb.push_back(8'hEF); sb.push_back(8'hBE);
    tick(1);
    alu_send = 1'b0;
    wait_idle("t2_idle");
    chk("t2_strobe_cnt", strobe_cnt, 3);
    chk("t2_gap", gap[2], 1);
    tick(2);

    // Simultaneous requests: reg first, alu after one idle cycle
    ovf_base = ovf_cnt;
    reg_send = 1'b1; reg_data = 8'h11; alu_send = 1'b1; alu_data = 16'h2233;
    sb.push_back(8'h11); sb.push_back(8'h33); sb.push_back(8'h22);
    tick(1);
    reg_send = 1'b0; alu_send = 1'b0;
    wait_idle("t3_idle");
    chk("t3_strobe_cnt", strobe_cnt, 6);
    chk("t3_gap_arb", gap[4], 2);
    chk("t3_gap_byte", gap[5], 1);
    chk("t3_no_ovf", ovf_cnt - ovf_base, 0);
    tick(2);

    // Overwrite of a pending reg request during an ALU transfer
    ovf_base = ovf_cnt;
    alu_send = 1'b1; alu_data = 16'h1234; sb.push_back(8'h34); sb.push_back(8'h12);
    tick(1);
    alu_send = 1'b0;
    wait_strobes(7, "t4_first_strobe");
    tick(2);
    reg_send = 1'b1; reg_data = 8'hA1;
    tick(1);
    reg_data = 8'hA2; sb.push_back(8'hA2);
    tick(1);
    reg_send = 1'b0;
    wait_idle("t4_idle");
    chk("t4_ovf_once", ovf_cnt - ovf_base, 1);
    chk("t4_strobe_cnt", strobe_cnt, 9);
    chk("t4_sb_empty", sb.size(), 0);
    tick(2);

    // Reset in WAIT_DONE of the first ALU byte with a reg request pending
    alu_send = 1'b1; alu_data = 16'h5566; sb.push_back(8'h66);
    tick(1);
    alu_send = 1'b0;
    wait_strobes(10, "t5_first_strobe");
    tick(2);
    reg_send = 1'b1; reg_data = 8'h77;
    tick(1);
    reg_send = 1'b0;
    tick(1);
    rst = 1'b0;
    #1;
    chk("t5_rst_tx_data", tx_data, 0);
    chk("t5_rst_tx_valid", tx_valid, 0);
    chk("t5_rst_ctrl_busy", ctrl_busy, 0);
    chk("t5_rst_ovf", ovf, 0);
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("t5_no_strobe", strobe_cnt, 10);
    chk("t5_ctrl_busy", ctrl_busy, 0);
    chk("t5_sb_empty", sb.size(), 0);

    // tx_busy never rises: FSM parks in WAIT_ACK
    busy_en = 1'b0;
    reg_send = 1'b1; reg_data = 8'h9C; sb.push_back(8'h9C);
    tick(1);
    reg_send = 1'b0;
    wait_strobes(11, "t6_strobe");
    tick(30);
    chk("t6_one_strobe", strobe_cnt, 11);
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_data_held", tx_data, 8'h9C);
    chk("t6_ctrl_busy", ctrl_busy, 1);
    chk("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
